prim_ram_2p_tiled: RTL

- Single-clock, one-write/one-read register-file memory of arbitrary Width × Depth.
- Tiled internally from fixed-geometry banks (BankDepth × BankWidth).
- Adds what a bare macro wrapper lacks: a post-reset zero-initialisation engine, a grant handshake, write-first collision forwarding, out-of-range protection and a read-valid strobe.
- Sits under peripheral FIFOs and scratch buffers that need deterministic contents after reset.

---
 rtl/prim_ram_2p_tiled_pkg.sv | 20 ++
 rtl/prim_ram_2p_bank.sv | 36 +++
 rtl/prim_ram_2p_tiled.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/prim_ram_2p_tiled_pkg.sv
// Shared types and elaboration-time helpers for the tiled 1W1R register-file memory.
package prim_ram_2p_tiled_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } init_state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 32'd1) / den;
  endfunction

  // Width of the row-bank select field; kept at least 1 bit so a single-row build still has a field.
  function automatic int unsigned bank_sel_w(input int unsigned depth, input int unsigned bank_depth);
    int unsigned n;
    n = ceil_div(depth, bank_depth);
    return (n > 32'd1) ? int'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/prim_ram_2p_bank.sv
// One physical BankDepth x BankWidth bank: 1 write port with per-bit enable,
// 1 synchronous read port, no reset on the storage or the read register.
module prim_ram_2p_bank #(
  parameter int unsigned BankDepth = 512,
  parameter int unsigned BankWidth = 32,
  localparam int unsigned BAw = $clog2(BankDepth)
) (
  input  logic                 i_clk,
  input  logic [BankWidth-1:0] i_wen,
  input  logic [BAw-1:0]       i_waddr,
  input  logic [BankWidth-1:0] i_wdata,
  input  logic                 i_re,
  input  logic [BAw-1:0]       i_raddr,
  output logic [BankWidth-1:0] o_rdata
);

  logic [BankWidth-1:0] r_mem [BankDepth];
  logic [BankWidth-1:0] r_rdata;

  // Bit-enabled write: only enabled bits take new data.
  always_ff @(posedge i_clk) begin
    if (|i_wen) begin
      r_mem[i_waddr] <= (r_mem[i_waddr] & ~i_wen) | (i_wdata & i_wen);
    end
  end

  // Registered read; the register holds between reads.
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/prim_ram_2p_tiled.sv
// Tiled single-clock 1W1R memory with post-reset zero-init engine, grant
// handshake, write-first collision forwarding, out-of-range protection and a
// read-valid strobe. Optional macro PRIM_RAM_2P_TILED_OUTREG_EN adds an output
// register stage (read latency 2 instead of 1).
module prim_ram_2p_tiled
  import prim_ram_2p_tiled_pkg::*;
#(
  parameter int unsigned Width           = 32,
  parameter int unsigned Depth           = 128,
  parameter int unsigned DataBitsPerMask = 1,
  parameter int unsigned BankWidth       = 32,
  parameter int unsigned BankDepth       = 512,
  localparam int unsigned Aw = $clog2(Depth),
  localparam int unsigned Mw = Width / DataBitsPerMask
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             a_req_i,
  output logic             a_gnt_o,
  input  logic [Aw-1:0]    a_addr_i,
  input  logic [Width-1:0] a_wdata_i,
  input  logic [Mw-1:0]    a_wmask_i,
  input  logic             b_req_i,
  output logic             b_gnt_o,
  input  logic [Aw-1:0]    b_addr_i,
  output logic             b_rvalid_o,
  output logic [Width-1:0] b_rdata_o,
  input  logic             init_req_i,
  output logic             init_busy_o
);

  localparam int unsigned NumRowBanks = ceil_div(Depth, BankDepth);
  localparam int unsigned NumColBanks = ceil_div(Width, BankWidth);
  localparam int unsigned BAw         = $clog2(BankDepth);
  localparam int unsigned RSw         = bank_sel_w(Depth, BankDepth);
  localparam int unsigned FAw         = BAw + RSw;
  localparam int unsigned PW          = NumColBanks * BankWidth;
  localparam logic [Aw:0]   DepthW    = (Aw + 1)'(Depth);
  localparam logic [Aw-1:0] LastAddr  = Aw'(Depth - 1);

  init_state_e r_state, w_state_nxt;
  logic [Aw-1:0] r_cnt, w_cnt_nxt;

  logic [FAw-1:0]   w_a_full, w_b_full, w_wr_addr;
  logic             w_a_inrange, w_b_inrange, w_collide;
  logic [Width-1:0] w_a_bitmask;
  logic             w_wr_en;
  logic [PW-1:0]    w_wr_data, w_wr_bits;

  logic [NumRowBanks-1:0][PW-1:0] w_row_rdata;
  logic [PW-1:0]    w_sel_rdata;
  logic [Width-1:0] w_rd_data;

  logic             r_rvalid;
  logic             r_rd_zero;
  logic [RSw-1:0]   r_row;
  logic [Width-1:0] r_fwd_bits, r_fwd_data;

  assign init_busy_o = (r_state == INIT);
  assign a_gnt_o     = a_req_i & ~init_busy_o;
  assign b_gnt_o     = b_req_i & ~init_busy_o;

  assign w_a_full    = FAw'(a_addr_i);
  assign w_b_full    = FAw'(b_addr_i);
  assign w_a_inrange = ({1'b0, a_addr_i} < DepthW);
  assign w_b_inrange = ({1'b0, b_addr_i} < DepthW);
  assign w_collide   = a_gnt_o & b_gnt_o & (a_addr_i == b_addr_i);

  // Init engine state and sweep counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Init sweep runs Depth cycles; a new request is only honoured from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      INIT: begin
        w_cnt_nxt = r_cnt + Aw'(1);
        if (r_cnt == LastAddr) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      IDLE: begin
        if (init_req_i) begin
          w_state_nxt = INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Expand the coarse write mask to one enable per data bit.
  always_comb begin
    w_a_bitmask = '0;
    for (int unsigned i = 0; i < Width; i++) begin
      w_a_bitmask[i] = a_wmask_i[i / DataBitsPerMask];
    end
  end

  // Shared write port: init sweep owns it while busy; padding bits always get 0.
  always_comb begin
    w_wr_en                = a_gnt_o & w_a_inrange;
    w_wr_addr              = w_a_full;
    w_wr_data              = PW'(a_wdata_i);
    w_wr_bits              = '1;
    w_wr_bits[Width-1:0]   = w_a_bitmask;
    if (r_state == INIT) begin
      w_wr_en   = 1'b1;
      w_wr_addr = FAw'(r_cnt);
      w_wr_data = '0;
      w_wr_bits = '1;
    end
  end

  for (genvar r = 0; r < NumRowBanks; r++) begin : g_row
    logic w_row_we;
    assign w_row_we = w_wr_en && (w_wr_addr[FAw-1:BAw] == RSw'(r));
    for (genvar c = 0; c < NumColBanks; c++) begin : g_col
      logic [BankWidth-1:0] w_bank_wen;
      assign w_bank_wen = w_row_we ? w_wr_bits[c*BankWidth +: BankWidth] : '0;
      prim_ram_2p_bank #(
        .BankDepth (BankDepth),
        .BankWidth (BankWidth)
      ) u_bank (
        .i_clk   (clk_i),
        .i_wen   (w_bank_wen),
        .i_waddr (w_wr_addr[BAw-1:0]),
        .i_wdata (w_wr_data[c*BankWidth +: BankWidth]),
        .i_re    (b_gnt_o),
        .i_raddr (w_b_full[BAw-1:0]),
        .o_rdata (w_row_rdata[r][c*BankWidth +: BankWidth])
      );
    end
  end

  // Read-side bookkeeping captured only on a granted read so the output holds otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid   <= 1'b0;
      r_rd_zero  <= 1'b1;
      r_row      <= '0;
      r_fwd_bits <= '0;
      r_fwd_data <= '0;
    end else begin
      r_rvalid <= b_gnt_o;
      if (b_gnt_o) begin
        r_rd_zero  <= ~w_b_inrange;
        r_row      <= w_b_full[FAw-1:BAw];
        r_fwd_bits <= w_collide ? w_a_bitmask : '0;
        r_fwd_data <= a_wdata_i;
      end
    end
  end

  // Row mux driven by the registered row select.
  always_comb begin
    w_sel_rdata = '0;
    for (int unsigned r = 0; r < NumRowBanks; r++) begin
      if (r_row == RSw'(r)) begin
        w_sel_rdata = w_row_rdata[r];
      end
    end
  end

  if (PW > Width) begin : g_pad
    logic w_unused_pad;
    assign w_unused_pad = ^w_sel_rdata[PW-1:Width];
  end

  // The bank returns pre-write data on a collision; overlay the forwarded write bits.
  assign w_rd_data = r_rd_zero ? '0
                   : ((w_sel_rdata[Width-1:0] & ~r_fwd_bits) | (r_fwd_data & r_fwd_bits));

`ifdef PRIM_RAM_2P_TILED_OUTREG_EN
  logic             r_rvalid_q;
  logic [Width-1:0] r_rdata_q;

  // Extra output stage; captures only valid stage-1 data so it holds between reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid_q <= 1'b0;
      r_rdata_q  <= '0;
    end else begin
      r_rvalid_q <= r_rvalid;
      if (r_rvalid) begin
        r_rdata_q <= w_rd_data;
      end
    end
  end

  assign b_rvalid_o = r_rvalid_q;
  assign b_rdata_o  = r_rdata_q;
`else
  assign b_rvalid_o = r_rvalid;
  assign b_rdata_o  = w_rd_data;
`endif

endmodule
